// File: rtl/interface_tag_core.sv
// Tag-tracking bridge: allocates the lowest free tag to each stream read request,
// forwards it to memory, and routes tagged responses back with their stream id.
module interface_tag_core #(
  parameter int addr_width   = 64,
  parameter int data_width   = 1024,
  parameter int nstrms       = 64,
  parameter int tag          = 256,
  parameter int l2_ncl       = 256,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int tag_width    = $clog2(tag),
  parameter int l2_ncl_width = $clog2(l2_ncl)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_v,
  output logic                    i_req_r,
  input  logic [nstrms_width-1:0] i_req_sid,
  input  logic [addr_width-1:0]   i_req_ea,
  output logic                    o_rsp_v,
  input  logic                    o_rsp_r,
  output logic [data_width-1:0]   o_rsp_d,
  output logic [nstrms_width-1:0] o_rsp_sid,
  output logic [l2_ncl_width-1:0] o_rsp_ptr,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  output logic [addr_width-1:0]   o_req_ea,
  output logic [tag_width-1:0]    o_req_tag,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r,
  input  logic [tag_width-1:0]    i_rsp_tag,
  input  logic [data_width-1:0]   i_rsp_data
);

  logic [tag-1:0]          busy;
  logic [tag-1:0]          busy_nxt;
  logic [tag_width-1:0]    free_tag;
  logic                    avail;
  logic                    req_fire;
  logic                    rsp_in_fire;
  logic                    rsp_out_fire;
  logic [nstrms_width-1:0] sid_tbl [tag];

  // Lowest-index free tag; scanning downward leaves the smallest index last.
  always_comb begin
    free_tag = '0;
    for (int i = tag - 1; i >= 0; i--) begin
      if (!busy[i]) free_tag = tag_width'(i);
    end
  end

  assign avail        = ~&busy;
  assign o_req_v      = i_req_v & avail;
  assign i_req_r      = o_req_r & avail;
  assign o_req_ea     = i_req_ea;
  assign o_req_tag    = free_tag;
  assign req_fire     = i_req_v & i_req_r;

  assign i_rsp_r      = ~o_rsp_v | o_rsp_r;
  assign rsp_in_fire  = i_rsp_v & i_rsp_r;
  assign rsp_out_fire = o_rsp_v & o_rsp_r;

  // The freed tag is still busy in the register, so alloc never picks it this cycle.
  always_comb begin
    busy_nxt = busy;
    if (rsp_out_fire) busy_nxt[o_rsp_ptr[tag_width-1:0]] = 1'b0;
    if (req_fire)     busy_nxt[free_tag] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (req_fire) sid_tbl[free_tag] <= i_req_sid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rsp_v   <= 1'b0;
      o_rsp_d   <= '0;
      o_rsp_sid <= '0;
      o_rsp_ptr <= '0;
    end else if (rsp_in_fire) begin
      o_rsp_v   <= 1'b1;
      o_rsp_d   <= i_rsp_data;
      o_rsp_sid <= sid_tbl[i_rsp_tag];
      o_rsp_ptr <= l2_ncl_width'(i_rsp_tag);
    end else if (rsp_out_fire) begin
      o_rsp_v   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interface_tag_core.sv
// Randomized and directed bench for interface_tag_core against a queue/array model
// of tag allocation, sid lookup and the one-entry response register.
module tb_interface_tag_core;

  logic          clk = 0;
  logic          reset = 1;
  logic          i_req_v = 0;
  logic          i_req_r;
  logic [5:0]    i_req_sid = 0;
  logic [63:0]   i_req_ea = 0;
  logic          o_rsp_v;
  logic          o_rsp_r = 1;
  logic [1023:0] o_rsp_d;
  logic [5:0]    o_rsp_sid;
  logic [7:0]    o_rsp_ptr;
  logic          o_req_v;
  logic          o_req_r = 1;
  logic [63:0]   o_req_ea;
  logic [7:0]    o_req_tag;
  logic          i_rsp_v = 0;
  logic          i_rsp_r;
  logic [7:0]    i_rsp_tag = 0;
  logic [1023:0] i_rsp_data = 0;

  interface_tag_core dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid), .i_req_ea(i_req_ea),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_d(o_rsp_d), .o_rsp_sid(o_rsp_sid),
    .o_rsp_ptr(o_rsp_ptr),
    .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_ea(o_req_ea), .o_req_tag(o_req_tag),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_tag(i_rsp_tag), .i_rsp_data(i_rsp_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1023:0] d;
    logic [5:0]    sid;
    logic [7:0]    tag;
  } ent_t;

  bit       mbusy [256];
  bit       mret  [256];
  bit [5:0] msid  [256];
  ent_t     hold  [$];
  bit       req_fire = 0;
  bit       rsp_fire = 0;

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits shown)", name, act[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [1023:0] rnd_data();
    logic [1023:0] v;
    for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model: free set + sid table + response queue of depth one, evaluated on stable inputs.
  always @(negedge clk) begin
    bit   avail;
    int   free;
    bit   take, load, alloc;
    ent_t e;
    if (reset) begin
      for (int i = 0; i < 256; i++) begin mbusy[i] = 0; mret[i] = 0; end
      hold.delete();
      req_fire = 0;
      rsp_fire = 0;
    end else begin
      avail = 0;
      free  = 0;
      for (int i = 255; i >= 0; i--) if (!mbusy[i]) begin avail = 1; free = i; end
      chk("o_req_v", o_req_v, i_req_v && avail);
      chk("i_req_r", i_req_r, o_req_r && avail);
      if (avail)   chk("o_req_tag", o_req_tag, free);
      if (i_req_v) chk("o_req_ea", o_req_ea, i_req_ea);
      chk("o_rsp_v", o_rsp_v, hold.size() > 0);
      if (hold.size() > 0) begin
        chk("o_rsp_d", o_rsp_d, hold[0].d);
        chk("o_rsp_sid", o_rsp_sid, hold[0].sid);
        chk("o_rsp_ptr", o_rsp_ptr, hold[0].tag);
      end
      chk("i_rsp_r", i_rsp_r, hold.size() == 0 || o_rsp_r);
      take  = hold.size() > 0 && o_rsp_r;
      load  = i_rsp_v && (hold.size() == 0 || o_rsp_r);
      alloc = i_req_v && o_req_r && avail;
      if (load) begin
        e.d = i_rsp_data; e.sid = msid[i_rsp_tag]; e.tag = i_rsp_tag;
        mret[i_rsp_tag] = 1;
      end
      if (take) begin
        mbusy[hold[0].tag] = 0;
        void'(hold.pop_front());
      end
      if (load) hold.push_back(e);
      if (alloc) begin
        mbusy[free] = 1;
        mret[free]  = 0;
        msid[free]  = i_req_sid;
      end
      req_fire = alloc;
      rsp_fire = load;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1023:0] d0, d1, da, db, ds;
  int cand [$];

  initial begin
    d0 = rnd_data(); d1 = rnd_data(); da = rnd_data(); db = rnd_data(); ds = rnd_data();
    repeat (3) tick();
    reset = 0;
    #1;
    chk("rst_o_rsp_v", o_rsp_v, 0);
    chk("rst_o_rsp_d", o_rsp_d, 0);
    chk("rst_o_rsp_sid", o_rsp_sid, 0);
    chk("rst_o_rsp_ptr", o_rsp_ptr, 0);
    chk("rst_i_req_r", i_req_r, 1);
    chk("rst_i_rsp_r", i_rsp_r, 1);

    // loopback: first request and a repeat three cycles later both get tag 0
    tick(); i_req_v = 1; i_req_sid = 1; i_req_ea = 64'h2;
    #1; chk("lb_tag", o_req_tag, 0); chk("lb_ea", o_req_ea, 64'h2); chk("lb_v", o_req_v, 1);
    tick(); i_req_v = 0; i_rsp_v = 1; i_rsp_tag = 0; i_rsp_data = d0;
    tick(); i_rsp_v = 0;
    #1; chk("lb_rsp_v", o_rsp_v, 1); chk("lb_rsp_sid", o_rsp_sid, 1);
    chk("lb_rsp_ptr", o_rsp_ptr, 0); chk("lb_rsp_d", o_rsp_d, d0);
    tick(); i_req_v = 1; i_req_sid = 1; i_req_ea = 64'h4;
    #1; chk("lb2_tag", o_req_tag, 0); chk("lb2_v", o_req_v, 1);
    tick(); i_req_v = 0; i_rsp_v = 1; i_rsp_tag = 0; i_rsp_data = d1;
    tick(); i_rsp_v = 0;
    #1; chk("lb2_rsp_sid", o_rsp_sid, 1); chk("lb2_rsp_ptr", o_rsp_ptr, 0); chk("lb2_rsp_d", o_rsp_d, d1);
    tick();

    // out-of-order return under output backpressure
    tick(); o_rsp_r = 0; i_req_v = 1; i_req_sid = 3; i_req_ea = 64'h100;
    #1; chk("ooo_tag0", o_req_tag, 0);
    tick(); i_req_sid = 5; i_req_ea = 64'h200;
    #1; chk("ooo_tag1", o_req_tag, 1);
    tick(); i_req_v = 0; i_rsp_v = 1; i_rsp_tag = 1; i_rsp_data = da;
    tick(); i_rsp_tag = 0; i_rsp_data = db;
    #1; chk("bp_held_v", o_rsp_v, 1); chk("bp_held_sid", o_rsp_sid, 5);
    chk("bp_held_ptr", o_rsp_ptr, 1); chk("bp_i_rsp_r", i_rsp_r, 0);
    tick();
    #1; chk("bp_still_d", o_rsp_d, da); chk("bp_still_i_rsp_r", i_rsp_r, 0);
    tick(); o_rsp_r = 1;
    #1; chk("bp_release_i_rsp_r", i_rsp_r, 1);
    tick(); i_rsp_v = 0;
    #1; chk("ooo2_v", o_rsp_v, 1); chk("ooo2_sid", o_rsp_sid, 3);
    chk("ooo2_ptr", o_rsp_ptr, 0); chk("ooo2_d", o_rsp_d, db);
    tick();
    #1; chk("ooo_drained", o_rsp_v, 0);

    // stale tag 1 returned while tag 0 is outstanding: old sid 5, tag 0 untouched
    tick(); i_req_v = 1; i_req_sid = 9; i_req_ea = 64'h300;
    #1; chk("stale_alloc0", o_req_tag, 0);
    tick(); i_req_v = 0; i_rsp_v = 1; i_rsp_tag = 1; i_rsp_data = ds;
    tick(); i_rsp_v = 0;
    #1; chk("stale_sid", o_rsp_sid, 5); chk("stale_ptr", o_rsp_ptr, 1);
    tick(); i_req_v = 1; i_req_sid = 10;
    #1; chk("stale_next_tag", o_req_tag, 1);
    tick(); i_req_v = 0; i_rsp_v = 1; i_rsp_tag = 0; i_rsp_data = rnd_data();
    tick(); i_rsp_tag = 1; i_rsp_data = rnd_data();
    tick(); i_rsp_v = 0;
    repeat (2) tick();

    // fill all 256 tags, then free tag 7 and reuse it
    for (int i = 0; i < 256; i++) begin
      tick(); i_req_v = 1; i_req_sid = 6'(i); i_req_ea = {$urandom, $urandom};
      #1; chk("fill_tag", o_req_tag, i);
    end
    tick();
    #1; chk("full_i_req_r", i_req_r, 0); chk("full_o_req_v", o_req_v, 0);
    i_rsp_v = 1; i_rsp_tag = 7; i_rsp_data = rnd_data();
    tick(); i_rsp_v = 0;
    #1; chk("full_rsp_ptr", o_rsp_ptr, 7); chk("full_still_stall", o_req_v, 0);
    tick();
    #1; chk("reuse_v", o_req_v, 1); chk("reuse_tag", o_req_tag, 7);
    tick(); i_req_v = 0;

    // reset with tags outstanding and a held response
    o_rsp_r = 0; i_rsp_v = 1; i_rsp_tag = 3; i_rsp_data = rnd_data();
    tick(); i_rsp_v = 0;
    #1; chk("pre_rst_v", o_rsp_v, 1);
    tick(); reset = 1;
    #1; chk("mid_rst_v", o_rsp_v, 0); chk("mid_rst_sid", o_rsp_sid, 0); chk("mid_rst_ptr", o_rsp_ptr, 0);
    repeat (2) tick();
    reset = 0; o_rsp_r = 1;
    tick(); i_req_v = 1; i_req_sid = 2; i_req_ea = 64'h40;
    #1; chk("post_rst_tag", o_req_tag, 0);
    tick(); i_req_v = 0;

    // random traffic; responses only for tags the model holds as outstanding
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (req_fire) i_req_v = 0;
      if (!i_req_v && $urandom_range(0, 99) < 60) begin
        i_req_v = 1; i_req_sid = 6'($urandom); i_req_ea = {$urandom, $urandom};
      end
      o_req_r = ($urandom_range(0, 99) < 80);
      o_rsp_r = ($urandom_range(0, 99) < 70);
      if (rsp_fire) i_rsp_v = 0;
      if (!i_rsp_v && $urandom_range(0, 99) < 50) begin
        cand.delete();
        for (int t = 0; t < 256; t++) if (mbusy[t] && !mret[t]) cand.push_back(t);
        if (cand.size() > 0) begin
          i_rsp_tag = 8'(cand[$urandom_range(0, cand.size() - 1)]);
          mret[i_rsp_tag] = 1;
          i_rsp_v = 1; i_rsp_data = rnd_data();
        end
      end
    end
    tick(); i_req_v = 0; i_rsp_v = 0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
